// File: rtl/id_stage_pkg.sv
// Shared RV32I decode definitions: opcodes, ALUOp encodings, the decoded control
// bundle and the opcode-to-control decoder used by the ID stage.
package id_stage_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALU_LDST = 2'b00;
    localparam logic [1:0] ALU_BR   = 2'b01;
    localparam logic [1:0] ALU_R    = 2'b10;
    localparam logic [1:0] ALU_I    = 2'b11;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {IMM_NONE, IMM_I, IMM_S, IMM_B} imm_sel_e;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       alu_src;
        logic       mem_to_reg;
        logic [1:0] alu_op;
        imm_sel_e   imm_sel;
        logic       uses_rs1;
        logic       uses_rs2;
        logic       illegal;
    } ctrl_t;

    // Unsupported opcodes decode to an all-zero bundle with only illegal set, so
    // they never read operands and therefore never raise a load-use stall.
    function automatic ctrl_t decode(input logic [6:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            OP_R: begin
                c.reg_write = 1'b1; c.alu_op = ALU_R;
                c.uses_rs1 = 1'b1; c.uses_rs2 = 1'b1;
            end
            OP_I: begin
                c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_op = ALU_I;
                c.imm_sel = IMM_I; c.uses_rs1 = 1'b1;
            end
            OP_LOAD: begin
                c.reg_write = 1'b1; c.mem_read = 1'b1; c.mem_to_reg = 1'b1;
                c.alu_src = 1'b1; c.alu_op = ALU_LDST; c.imm_sel = IMM_I;
                c.uses_rs1 = 1'b1;
            end
            OP_STORE: begin
                c.mem_write = 1'b1; c.alu_src = 1'b1; c.alu_op = ALU_LDST;
                c.imm_sel = IMM_S; c.uses_rs1 = 1'b1; c.uses_rs2 = 1'b1;
            end
            OP_BRANCH: begin
                c.branch = 1'b1; c.alu_op = ALU_BR; c.imm_sel = IMM_B;
                c.uses_rs1 = 1'b1; c.uses_rs2 = 1'b1;
            end
            default: c.illegal = 1'b1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/id_stage_reg_file.sv
// 2-read/1-write register file with async clear, hardwired x0 and a same-cycle
// WB-to-read bypass so ID never sees a stale value for the register being written.
module id_stage_reg_file #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] wd,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2
);

    logic [NREGS-1:0][XLEN-1:0] regs;
    logic                       wr_en;
    logic                       byp1;
    logic                       byp2;

    assign wr_en = we && (wa != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            regs <= '0;
        else if (wr_en)
            regs[wa] <= wd;
    end

    // Bypass is held off during reset so reads show the cleared file.
    assign byp1 = !rst && wr_en && (wa == ra1);
    assign byp2 = !rst && wr_en && (wa == ra2);

    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (byp1)
            rd1 = wd;
        else if (ra1 != '0)
            rd1 = regs[ra1];
        if (byp2)
            rd2 = wd;
        else if (ra2 != '0)
            rd2 = regs[ra2];
    end

endmodule

// File: rtl/id_stage.sv
// RV32I instruction-decode stage: control decode, immediate generation, register
// read with WB bypass, load-use hazard detection and a running stall counter.
module id_stage
    import id_stage_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  pc_in,
    input  logic [31:0]      instr_in,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             branch_flush,
    input  logic             wb_reg_write,
    input  logic [4:0]       wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             Branch,
    output logic             ALUSrc,
    output logic             MemToReg,
    output logic [1:0]       ALUOp,
    output logic [XLEN-1:0]  pc_out,
    output logic [XLEN-1:0]  read_data1,
    output logic [XLEN-1:0]  read_data2,
    output logic [XLEN-1:0]  immediate,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [4:0]       rd,
    output logic [2:0]       funct3,
    output logic             funct7,
    output logic [31:0]      instr_out,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_flush,
    output logic             illegal_instr,
    output logic [CNT_W-1:0] stall_count
);

    ctrl_t       dec;
    logic [31:0] imm32;
    logic        stall;
    logic        hold;

    assign dec       = decode(instr_in[6:0]);
    assign rs1       = instr_in[19:15];
    assign rs2       = instr_in[24:20];
    assign rd        = instr_in[11:7];
    assign funct3    = instr_in[14:12];
    assign funct7    = instr_in[30];
    assign instr_out = instr_in;
    assign pc_out    = pc_in;

    always_comb begin
        imm32 = '0;
        case (dec.imm_sel)
            IMM_I:   imm32 = {{20{instr_in[31]}}, instr_in[31:20]};
            IMM_S:   imm32 = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
            IMM_B:   imm32 = {{19{instr_in[31]}}, instr_in[31], instr_in[7],
                              instr_in[30:25], instr_in[11:8], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign immediate = XLEN'(signed'(imm32));

    assign RegWrite      = !rst && dec.reg_write;
    assign MemRead       = !rst && dec.mem_read;
    assign MemWrite      = !rst && dec.mem_write;
    assign Branch        = !rst && dec.branch;
    assign ALUSrc        = !rst && dec.alu_src;
    assign MemToReg      = !rst && dec.mem_to_reg;
    assign ALUOp         = rst ? 2'b00 : dec.alu_op;
    assign illegal_instr = !rst && dec.illegal;

    // The load in EX lands one cycle later; a single bubble covers the gap.
    assign stall = !rst && ex_mem_read && (ex_rd != 5'd0) &&
                   (((ex_rd == rs1) && dec.uses_rs1) || ((ex_rd == rs2) && dec.uses_rs2));

    // A taken branch squashes the dependent instruction, so the stall is moot.
    assign hold        = stall && !branch_flush;
    assign pc_write    = !hold;
    assign if_id_write = !hold;
    assign id_ex_flush = !rst && (branch_flush || stall);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_count <= '0;
        else if (hold)
            stall_count <= stall_count + 1'b1;
    end

    id_stage_reg_file #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_reg_file (
        .clk (clk),
        .rst (rst),
        .ra1 (rs1),
        .ra2 (rs2),
        .we  (wb_reg_write),
        .wa  (wb_rd),
        .wd  (wb_data),
        .rd1 (read_data1),
        .rd2 (read_data2)
    );

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed vector table, hand sequences for
// bypass/x0/wrap/reset corners, and random traffic against a reference model.
module tb_id_stage;

    localparam int CW   = 4;
    localparam int CMOD = 1 << CW;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   pc_in, instr_in, wb_data;
    logic          ex_mem_read, branch_flush, wb_reg_write;
    logic [4:0]    ex_rd, wb_rd;
    logic          RegWrite, MemRead, MemWrite, Branch, ALUSrc, MemToReg;
    logic [1:0]    ALUOp;
    logic [31:0]   pc_out, read_data1, read_data2, immediate, instr_out;
    logic [4:0]    rs1, rs2, rd;
    logic [2:0]    funct3;
    logic          funct7, pc_write, if_id_write, id_ex_flush, illegal_instr;
    logic [CW-1:0] stall_count;

    id_stage #(.XLEN(32), .NREGS(32), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .instr_in(instr_in),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .branch_flush(branch_flush),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch),
        .ALUSrc(ALUSrc), .MemToReg(MemToReg), .ALUOp(ALUOp), .pc_out(pc_out),
        .read_data1(read_data1), .read_data2(read_data2), .immediate(immediate),
        .rs1(rs1), .rs2(rs2), .rd(rd), .funct3(funct3), .funct7(funct7),
        .instr_out(instr_out), .pc_write(pc_write), .if_id_write(if_id_write),
        .id_ex_flush(id_ex_flush), .illegal_instr(illegal_instr), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] mrf [32];
    int          mcnt;

    typedef struct {
        logic [31:0] instr;
        logic        emr;
        logic [4:0]  exr;
        logic        bf;
        logic [5:0]  ctrl;  // {RegWrite,MemRead,MemWrite,Branch,ALUSrc,MemToReg}
        logic [1:0]  aop;
        logic [31:0] imm;
        logic        ill;
        logic [2:0]  haz;   // {pc_write,if_id_write,id_ex_flush}
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference decode straight from the ISA tables; immediates by integer arithmetic.
    function automatic void ref_dec(input logic [31:0] ins, output logic [5:0] c,
                                    output logic [1:0] aop, output logic [31:0] imm,
                                    output logic ill, output logic u1, output logic u2);
        int sv;
        sv = $signed(ins);
        c = '0; aop = '0; imm = '0; ill = 1'b0; u1 = 1'b0; u2 = 1'b0;
        case (ins[6:0])
            7'h33: begin c = 6'b100000; aop = 2'd2; u1 = 1; u2 = 1; end
            7'h13: begin c = 6'b100010; aop = 2'd3; imm = sv >>> 20; u1 = 1; end
            7'h03: begin c = 6'b110011; aop = 2'd0; imm = sv >>> 20; u1 = 1; end
            7'h23: begin c = 6'b001010; aop = 2'd0; u1 = 1; u2 = 1;
                         imm = (sv >>> 25) * 32 + int'(ins[11:7]); end
            7'h63: begin c = 6'b000100; aop = 2'd1; u1 = 1; u2 = 1;
                         imm = (sv >>> 31) * 4096 + int'(ins[7]) * 2048 +
                               int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2; end
            default: ill = 1'b1;
        endcase
    endfunction

    function automatic logic ref_stall();
        logic [5:0] c; logic [1:0] a; logic [31:0] i; logic il, u1, u2;
        ref_dec(instr_in, c, a, i, il, u1, u2);
        return ex_mem_read && ex_rd != 0 &&
               ((ex_rd == instr_in[19:15] && u1) || (ex_rd == instr_in[24:20] && u2));
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] r);
        if (wb_reg_write && wb_rd != 0 && wb_rd == r) return wb_data;
        return (r == 0) ? 32'd0 : mrf[r];
    endfunction

    task automatic check_model(input string tag);
        logic [5:0] c; logic [1:0] a; logic [31:0] i; logic il, u1, u2, st, h;
        ref_dec(instr_in, c, a, i, il, u1, u2);
        st = ref_stall();
        h  = st && !branch_flush;
        chk({tag, ".ctrl"}, 32'({RegWrite, MemRead, MemWrite, Branch, ALUSrc, MemToReg, ALUOp}), 32'({c, a}));
        chk({tag, ".imm"}, immediate, i);
        chk({tag, ".ill"}, 32'(illegal_instr), 32'(il));
        chk({tag, ".rd1"}, read_data1, ref_read(instr_in[19:15]));
        chk({tag, ".rd2"}, read_data2, ref_read(instr_in[24:20]));
        chk({tag, ".haz"}, 32'({pc_write, if_id_write, id_ex_flush}), 32'({!h, !h, branch_flush || st}));
        chk({tag, ".cnt"}, 32'(stall_count), 32'(mcnt));
        chk({tag, ".flds"}, 32'({rs1, rs2, rd, funct3, funct7}),
            32'({instr_in[19:15], instr_in[24:20], instr_in[11:7], instr_in[14:12], instr_in[30]}));
        chk({tag, ".pass"}, pc_out ^ instr_out, pc_in ^ instr_in);
    endtask

    task automatic drive(input logic [31:0] ins, input logic emr, input logic [4:0] exr,
                         input logic bf, input logic wbw, input logic [4:0] wrd, input logic [31:0] wd);
        instr_in = ins; ex_mem_read = emr; ex_rd = exr; branch_flush = bf;
        wb_reg_write = wbw; wb_rd = wrd; wb_data = wd;
        pc_in = $urandom();
        #2;
    endtask

    task automatic tick();
        logic st;
        st = ref_stall();
        @(posedge clk);
        if (wb_reg_write && wb_rd != 0) mrf[wb_rd] = wb_data;
        if (st && !branch_flush) mcnt = (mcnt + 1) % CMOD;
        #1;
    endtask

    initial begin
        logic [31:0] r, ins;
        logic [6:0]  op;
        logic        saw_wrap;

        vecs[0]  = '{32'hFFF00093, 1'b0, 5'd0, 1'b0, 6'b100010, 2'd3, 32'hFFFFFFFF, 1'b0, 3'b110};
        vecs[1]  = '{32'h004101B3, 1'b1, 5'd2, 1'b0, 6'b100000, 2'd2, 32'h0,        1'b0, 3'b001};
        vecs[2]  = '{32'h004101B3, 1'b1, 5'd0, 1'b0, 6'b100000, 2'd2, 32'h0,        1'b0, 3'b110};
        vecs[3]  = '{32'h004101B3, 1'b1, 5'd2, 1'b1, 6'b100000, 2'd2, 32'h0,        1'b0, 3'b111};
        vecs[4]  = '{32'h0000806F, 1'b1, 5'd1, 1'b0, 6'b000000, 2'd0, 32'h0,        1'b1, 3'b110};
        vecs[5]  = '{32'h00000000, 1'b1, 5'd0, 1'b0, 6'b000000, 2'd0, 32'h0,        1'b1, 3'b110};
        vecs[6]  = '{32'h00000013, 1'b0, 5'd0, 1'b0, 6'b100010, 2'd3, 32'h0,        1'b0, 3'b110};
        vecs[7]  = '{32'hFFC32283, 1'b1, 5'd6, 1'b0, 6'b110011, 2'd0, 32'hFFFFFFFC, 1'b0, 3'b001};
        vecs[8]  = '{32'h00510093, 1'b1, 5'd5, 1'b0, 6'b100010, 2'd3, 32'h5,        1'b0, 3'b110};
        vecs[9]  = '{32'h00732423, 1'b1, 5'd7, 1'b0, 6'b001010, 2'd0, 32'h8,        1'b0, 3'b001};
        vecs[10] = '{32'hFE112FA3, 1'b0, 5'd0, 1'b0, 6'b001010, 2'd0, 32'hFFFFFFFF, 1'b0, 3'b110};
        vecs[11] = '{32'hFE208CE3, 1'b1, 5'd2, 1'b0, 6'b000100, 2'd1, 32'hFFFFFFF8, 1'b0, 3'b001};
        vecs[12] = '{32'h00000863, 1'b1, 5'd0, 1'b0, 6'b000100, 2'd1, 32'h10,       1'b0, 3'b110};
        vecs[13] = '{32'h000000B7, 1'b1, 5'd1, 1'b0, 6'b000000, 2'd0, 32'h0,        1'b1, 3'b110};

        for (int k = 0; k < 32; k++) mrf[k] = '0;
        mcnt = 0;

        // Reset state: a would-be stalling instruction must look inert.
        rst = 1'b1;
        drive(32'h004101B3, 1'b1, 5'd2, 1'b0, 1'b0, 5'd0, 32'h0);
        chk("rst.haz", 32'({pc_write, if_id_write, id_ex_flush}), 32'b110);
        chk("rst.ctrl", 32'({RegWrite, MemRead, MemWrite, Branch, ALUSrc, MemToReg, ALUOp}), 32'h0);
        chk("rst.cnt", 32'(stall_count), 32'h0);
        chk("rst.rd1", read_data1, 32'h0);
        instr_in = 32'h0000006F; #1;
        chk("rst.ill", 32'(illegal_instr), 32'h0);
        @(negedge clk); rst = 1'b0;

        foreach (vecs[v]) begin
            drive(vecs[v].instr, vecs[v].emr, vecs[v].exr, vecs[v].bf, 1'b0, 5'd0, 32'h0);
            chk($sformatf("vec%0d.ctrl", v), 32'({RegWrite, MemRead, MemWrite, Branch, ALUSrc, MemToReg}), 32'(vecs[v].ctrl));
            chk($sformatf("vec%0d.aluop", v), 32'(ALUOp), 32'(vecs[v].aop));
            chk($sformatf("vec%0d.imm", v), immediate, vecs[v].imm);
            chk($sformatf("vec%0d.ill", v), 32'(illegal_instr), 32'(vecs[v].ill));
            chk($sformatf("vec%0d.haz", v), 32'({pc_write, if_id_write, id_ex_flush}), 32'(vecs[v].haz));
            chk($sformatf("vec%0d.cnt", v), 32'(stall_count), 32'(mcnt));
            tick();
        end
        chk("table.cnt", 32'(stall_count), 32'd4);

        // WB then read, with the same-cycle bypass on the write cycle.
        drive(32'h000280B3, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF);
        chk("byp.rd1", read_data1, 32'hDEADBEEF);
        tick();
        drive(32'h000280B3, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0);
        chk("wb.rd1", read_data1, 32'hDEADBEEF);
        check_model("wb");
        tick();

        // Writes to x0 are dropped, including through the bypass path.
        drive(32'h000000B3, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 32'h1234);
        chk("x0.byp", read_data1, 32'h0);
        tick();
        drive(32'h000000B3, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0);
        chk("x0.rd1", read_data1, 32'h0);
        tick();

        // Hold a load-use stall long enough for the counter to wrap.
        saw_wrap = 1'b0;
        for (int n = 0; n < CMOD + 2; n++) begin
            drive(32'h004101B3, 1'b1, 5'd4, 1'b0, 1'b0, 5'd0, 32'h0);
            check_model("wrap");
            if (mcnt == CMOD - 1) begin
                tick();
                chk("wrap.zero", 32'(stall_count), 32'h0);
                saw_wrap = 1'b1;
            end else begin
                tick();
            end
        end
        chk("wrap.seen", 32'(saw_wrap), 32'h1);

        // Random traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            r = $urandom();
            case ($urandom_range(0, 7))
                0: op = 7'h33; 1: op = 7'h13; 2: op = 7'h03; 3: op = 7'h23;
                4: op = 7'h63; 5: op = 7'h6F; 6: op = 7'h37;
                default: op = 7'($urandom());
            endcase
            ins = {r[31:7], op};
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
            drive(ins, ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) != 0),
                  5'($urandom_range(0, 7)), $urandom());
            check_model("rand");
            tick();
        end

        // Reset asserted in the middle of a stall releases it at once.
        drive(32'h004101B3, 1'b1, 5'd2, 1'b0, 1'b0, 5'd0, 32'h0);
        chk("mid.pre", 32'(pc_write), 32'h0);
        #1 rst = 1'b1;
        #1;
        chk("mid.haz", 32'({pc_write, if_id_write, id_ex_flush}), 32'b110);
        chk("mid.cnt", 32'(stall_count), 32'h0);
        chk("mid.ctrl", 32'({RegWrite, ALUOp}), 32'h0);
        for (int k = 0; k < 32; k++) mrf[k] = '0;
        mcnt = 0;
        instr_in = 32'h00028133; #1;
        chk("mid.rf", read_data1, 32'h0);
        #1 rst = 1'b0;
        instr_in = 32'h004101B3;
        #1;
        check_model("post");
        tick();
        check_model("post2");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
